mem_arb_nport: RTL and testbench

Parametrised multi-port single-bank memory: NUM_PORTS independent requesters share one WIDTH x DEPTH storage array through a round-robin arbiter, each with its own valid/ready handshake. Successor to the single-port valid/ready memory: adds per-byte write enables, a registered read-data return with a per-port read-valid strobe, and out-of-range address detection for non-power-of-two depths. Sits between bus masters (DMA, CPU-side adapters) and on-chip storage.

---
 rtl/mem_arb_nport_if.sv | 47 ++++
 rtl/mem_arb_nport.sv | 144 ++++++++++++++
 tb/tb_mem_arb_nport.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_nport_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arb_nport_if
//  Purpose  : Bundle of the per-port request/response signals of the
//             multi-port arbitrated memory. Port p occupies bit p of every
//             NUM_PORTS-wide vector and slice p of every packed field.
//  Modports : master - requester side (drives requests, sees grants/data)
//             slave  - memory side   (sees requests, drives grants/data)
//  Signals  : valid_i   request valid, one bit per port
//             wr_rd_i   1 = write, 0 = read
//             addr_i    word address, port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
//             wdata_i   write data, port p at [p*WIDTH +: WIDTH]
//             be_i      byte enables, port p at [p*WIDTH/8 +: WIDTH/8]
//             ready_o   grant, at most one bit set
//             rdata_o   registered read data shared by all ports
//             rvalid_o  one-hot owner of rdata_o this cycle
//             err_o     one-cycle out-of-range pulse for an accepted request
//  Revision : 1.0 - initial release
// ============================================================================
interface mem_arb_nport_if #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 6,
  parameter int NUM_PORTS  = 2
);

  logic [NUM_PORTS-1:0]              valid_i;
  logic [NUM_PORTS-1:0]              wr_rd_i;
  logic [NUM_PORTS*ADDR_WIDTH-1:0]   addr_i;
  logic [NUM_PORTS*WIDTH-1:0]        wdata_i;
  logic [NUM_PORTS*(WIDTH/8)-1:0]    be_i;
  logic [NUM_PORTS-1:0]              ready_o;
  logic [WIDTH-1:0]                  rdata_o;
  logic [NUM_PORTS-1:0]              rvalid_o;
  logic [NUM_PORTS-1:0]              err_o;

  modport master (
    output valid_i, wr_rd_i, addr_i, wdata_i, be_i,
    input  ready_o, rdata_o, rvalid_o, err_o
  );

  modport slave (
    input  valid_i, wr_rd_i, addr_i, wdata_i, be_i,
    output ready_o, rdata_o, rvalid_o, err_o
  );

endinterface
`default_nettype wire

// File: rtl/mem_arb_nport.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arb_nport
//  Purpose  : NUM_PORTS requesters share one WIDTH x DEPTH storage array
//             through a combinational round-robin arbiter. Writes honour
//             per-byte enables; reads return registered data one cycle after
//             the transfer with a one-hot rvalid naming the owning port.
//             Addresses >= DEPTH complete the handshake but are flagged on
//             err_o (writes dropped, reads return zero).
//  Ports    : clk_i    clock, rising edge
//             rst_n_i  asynchronous active-low reset
//             bus      mem_arb_nport_if.slave (requests in, grant/data out)
//  Revision : 1.0 - initial release
// ============================================================================
module mem_arb_nport #(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int NUM_PORTS  = 2
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  mem_arb_nport_if.slave  bus
);

  localparam int BYTES = WIDTH / 8;
  // Pointer keeps at least one bit so a single-port build still elaborates.
  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [PTR_W-1:0]      LAST_PORT   = PTR_W'(NUM_PORTS - 1);
  // One extra bit so DEPTH itself is representable for the range compare.
  localparam logic [ADDR_WIDTH:0]   DEPTH_LIMIT = (ADDR_WIDTH + 1)'(DEPTH);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [PTR_W-1:0]      ptr_q,    ptr_d;
  logic [WIDTH-1:0]      rdata_q,  rdata_d;
  logic [NUM_PORTS-1:0]  rvalid_q, rvalid_d;
  logic [NUM_PORTS-1:0]  err_q,    err_d;

  // --------------------------------------------------------------------------
  // Arbiter and selected request
  // --------------------------------------------------------------------------
  logic [NUM_PORTS-1:0]  grant;
  logic [PTR_W-1:0]      grant_idx;
  logic                  grant_any;
  int                    scan_idx;

  logic                  sel_wr;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [WIDTH-1:0]      sel_wdata;
  logic [BYTES-1:0]      sel_be;
  logic                  sel_in_range;
  logic                  mem_we;

  // Scan upward from the priority pointer, wrapping modulo NUM_PORTS; the
  // first requester found wins. Purely combinational so an uncontested
  // request is granted in the same cycle it is raised.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    scan_idx  = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      scan_idx = (int'(ptr_q) + i) % NUM_PORTS;
      if (!grant_any && bus.valid_i[scan_idx]) begin
        grant[scan_idx] = 1'b1;
        grant_idx       = PTR_W'(scan_idx);
        grant_any       = 1'b1;
      end
    end
  end

  // Only the granted port's fields matter; a grant implies a transfer.
  always_comb begin
    sel_wr    = bus.wr_rd_i[grant_idx];
    sel_addr  = bus.addr_i [grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
    sel_wdata = bus.wdata_i[grant_idx*WIDTH      +: WIDTH];
    sel_be    = bus.be_i   [grant_idx*BYTES      +: BYTES];
  end

  assign sel_in_range = ({1'b0, sel_addr} < DEPTH_LIMIT);

  // The array has no reset, so a write presented while reset is held must
  // be suppressed explicitly; rst_n_i gates the write strobe.
  assign mem_we = grant_any && sel_wr && sel_in_range && rst_n_i;

  // --------------------------------------------------------------------------
  // Storage: byte-granular write, contents survive reset
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < BYTES; b++) begin
      if (mem_we && sel_be[b]) begin
        mem_q[sel_addr][8*b +: 8] <= sel_wdata[8*b +: 8];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next-state for pointer and registered response
  // --------------------------------------------------------------------------
  always_comb begin
    ptr_d    = ptr_q;
    rdata_d  = rdata_q;   // read data is held until the next read
    rvalid_d = '0;
    err_d    = '0;
    if (grant_any) begin
      ptr_d = (grant_idx == LAST_PORT) ? '0 : grant_idx + 1'b1;
      if (!sel_in_range) begin
        err_d = grant;
      end
      if (!sel_wr) begin
        rvalid_d = grant;
        // Out-of-range reads still produce a response, but with zero data.
        rdata_d  = sel_in_range ? mem_q[sel_addr] : '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ptr_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= '0;
      err_q    <= '0;
    end else begin
      ptr_q    <= ptr_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.ready_o  = grant;
  assign bus.rdata_o  = rdata_q;
  assign bus.rvalid_o = rvalid_q;
  assign bus.err_o    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arb_nport.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_arb_nport
//  Purpose  : Self-checking bench for mem_arb_nport. Instance A uses
//             DEPTH=64, instance B uses DEPTH=48 (non-power-of-two depth with
//             reachable out-of-range addresses). Directed vector tables,
//             hand-written reset/contention sequences and a randomized run on
//             instance B compared against a behavioural reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arb_nport;

  localparam int WIDTH   = 16;
  localparam int AW      = 6;
  localparam int NP      = 2;
  localparam int DEPTH_B = 48;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_arb_nport_if #(.WIDTH(WIDTH), .ADDR_WIDTH(AW), .NUM_PORTS(NP)) bus_a ();
  mem_arb_nport_if #(.WIDTH(WIDTH), .ADDR_WIDTH(AW), .NUM_PORTS(NP)) bus_b ();

  mem_arb_nport #(.WIDTH(WIDTH), .DEPTH(64), .ADDR_WIDTH(AW), .NUM_PORTS(NP)) dut_a (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus_a)
  );

  mem_arb_nport #(.WIDTH(WIDTH), .DEPTH(DEPTH_B), .ADDR_WIDTH(AW), .NUM_PORTS(NP)) dut_b (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus_b)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Vector records
  // --------------------------------------------------------------------------
  typedef struct {
    logic [1:0]  valid;
    logic [1:0]  wr;
    logic [5:0]  a0, a1;
    logic [15:0] d0, d1;
    logic [1:0]  be0, be1;
    logic [1:0]  exp_ready;
    logic [1:0]  exp_rvalid;
    logic [15:0] exp_rdata;
    logic [1:0]  exp_err;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] valid, input logic [1:0] wr,
                              input logic [5:0] a0, input logic [5:0] a1,
                              input logic [15:0] d0, input logic [15:0] d1,
                              input logic [1:0] be0, input logic [1:0] be1,
                              input logic [1:0] er, input logic [1:0] ev,
                              input logic [15:0] ed, input logic [1:0] ee);
    vec_t v;
    v.valid = valid; v.wr = wr; v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
    v.be0 = be0; v.be1 = be1; v.exp_ready = er; v.exp_rvalid = ev;
    v.exp_rdata = ed; v.exp_err = ee;
    return v;
  endfunction

  task automatic drive_a(input logic [1:0] valid, input logic [1:0] wr,
                         input logic [5:0] a0, input logic [5:0] a1,
                         input logic [15:0] d0, input logic [15:0] d1,
                         input logic [1:0] be0, input logic [1:0] be1);
    bus_a.valid_i = valid;
    bus_a.wr_rd_i = wr;
    bus_a.addr_i  = {a1, a0};
    bus_a.wdata_i = {d1, d0};
    bus_a.be_i    = {be1, be0};
  endtask

  task automatic idle_all();
    drive_a(2'b00, 2'b00, 6'd0, 6'd0, 16'h0, 16'h0, 2'b00, 2'b00);
    bus_b.valid_i = '0; bus_b.wr_rd_i = '0; bus_b.addr_i = '0;
    bus_b.wdata_i = '0; bus_b.be_i = '0;
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst_n = 1'b0;
    idle_all();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One row = one cycle: drive after the edge, sample mid-cycle.
  task automatic apply_vec(input vec_t v, input bit on_b, input string tag);
    logic [1:0]  r, rv, e;
    logic [15:0] d;
    @(posedge clk);
    #1;
    if (on_b) begin
      bus_b.valid_i = v.valid; bus_b.wr_rd_i = v.wr; bus_b.addr_i = {v.a1, v.a0};
      bus_b.wdata_i = {v.d1, v.d0}; bus_b.be_i = {v.be1, v.be0};
    end else begin
      drive_a(v.valid, v.wr, v.a0, v.a1, v.d0, v.d1, v.be0, v.be1);
    end
    @(negedge clk);
    r  = on_b ? bus_b.ready_o  : bus_a.ready_o;
    rv = on_b ? bus_b.rvalid_o : bus_a.rvalid_o;
    d  = on_b ? bus_b.rdata_o  : bus_a.rdata_o;
    e  = on_b ? bus_b.err_o    : bus_a.err_o;
    check({tag, " ready"},  32'(r),  32'(v.exp_ready));
    check({tag, " rvalid"}, 32'(rv), 32'(v.exp_rvalid));
    check({tag, " rdata"},  32'(d),  32'(v.exp_rdata));
    check({tag, " err"},    32'(e),  32'(v.exp_err));
  endtask

  // --------------------------------------------------------------------------
  // Reference model for instance B (round-robin rule + array of words)
  // --------------------------------------------------------------------------
  logic [15:0] m_mem [64];
  logic [15:0] m_rdata;
  logic [1:0]  m_rvalid, m_err;
  int          m_ptr;

  logic [1:0]  s_valid, s_wr;
  logic [5:0]  s_addr [2];
  logic [15:0] s_data [2];
  logic [1:0]  s_be   [2];

  function automatic logic [1:0] model_grant(input logic [1:0] v, input int ptr);
    for (int i = 0; i < 2; i++) begin
      int idx = (ptr + i) % 2;
      if (v[idx]) return 2'(1 << idx);
    end
    return 2'b00;
  endfunction

  task automatic model_edge(input logic [1:0] g);
    int p, a;
    m_rvalid = 2'b00;
    m_err    = 2'b00;
    if (g != 2'b00) begin
      p     = g[1] ? 1 : 0;
      m_ptr = (p + 1) % 2;
      a     = int'(s_addr[p]);
      if (a >= DEPTH_B) m_err = g;
      if (!s_wr[p]) begin
        m_rvalid = g;
        m_rdata  = (a >= DEPTH_B) ? 16'h0000 : m_mem[a];
      end else if (a < DEPTH_B) begin
        for (int b = 0; b < 2; b++)
          if (s_be[p][b]) m_mem[a][8*b +: 8] = s_data[p][8*b +: 8];
      end
    end
  endtask

  task automatic push_b();
    bus_b.valid_i = s_valid;
    bus_b.wr_rd_i = s_wr;
    bus_b.addr_i  = {s_addr[1], s_addr[0]};
    bus_b.wdata_i = {s_data[1], s_data[0]};
    bus_b.be_i    = {s_be[1], s_be[0]};
  endtask

  task automatic rand_cycle(output logic [1:0] g);
    @(posedge clk);
    #1;
    push_b();
    @(negedge clk);
    g = model_grant(s_valid, m_ptr);
    check("rnd ready",  32'(bus_b.ready_o),  32'(g));
    check("rnd rvalid", 32'(bus_b.rvalid_o), 32'(m_rvalid));
    check("rnd err",    32'(bus_b.err_o),    32'(m_err));
    check("rnd rdata",  32'(bus_b.rdata_o),  32'(m_rdata));
    model_edge(g);
  endtask

  vec_t tbl_a [17];
  vec_t tbl_b [6];

  initial begin
    logic [1:0] g, last_g;

    // ---------------------------------------------------------------- tables
    tbl_a[0]  = mk(2'b01, 2'b01, 6'd5,  6'd0,  16'hA5C3, 16'h0000, 2'b11, 2'b00, 2'b01, 2'b00, 16'h0000, 2'b00);
    tbl_a[1]  = mk(2'b01, 2'b00, 6'd5,  6'd0,  16'h0000, 16'h0000, 2'b00, 2'b00, 2'b01, 2'b00, 16'h0000, 2'b00);
    tbl_a[2]  = mk(2'b00, 2'b00, 6'd0,  6'd0,  16'h0000, 16'h0000, 2'b00, 2'b00, 2'b00, 2'b01, 16'hA5C3, 2'b00);
    tbl_a[3]  = mk(2'b00, 2'b00, 6'd0,  6'd0,  16'h0000, 16'h0000, 2'b00, 2'b00, 2'b00, 2'b00, 16'hA5C3, 2'b00);
    tbl_a[4]  = mk(2'b01, 2'b01, 6'd10, 6'd0,  16'h1234, 16'h0000, 2'b11, 2'b00, 2'b01, 2'b00, 16'hA5C3, 2'b00);
    tbl_a[5]  = mk(2'b10, 2'b10, 6'd0,  6'd10, 16'h0000, 16'hFFFF, 2'b00, 2'b10, 2'b10, 2'b00, 16'hA5C3, 2'b00);
    tbl_a[6]  = mk(2'b01, 2'b00, 6'd10, 6'd0,  16'h0000, 16'h0000, 2'b00, 2'b00, 2'b01, 2'b00, 16'hA5C3, 2'b00);
    tbl_a[7]  = mk(2'b10, 2'b10, 6'd0,  6'd10, 16'h0000, 16'h0000, 2'b00, 2'b00, 2'b10, 2'b01, 16'hFF34, 2'b00);
    tbl_a[8]  = mk(2'b01, 2'b00, 6'd10, 6'd0,  16'h0000, 16'h0000, 2'b00, 2'b00, 2'b01, 2'b00, 16'hFF34, 2'b00);
    tbl_a[9]  = mk(2'b00, 2'b00, 6'd0,  6'd0,  16'h0000, 16'h0000, 2'b00, 2'b00, 2'b00, 2'b01, 16'hFF34, 2'b00);
    tbl_a[10] = mk(2'b10, 2'b10, 6'd0,  6'd63, 16'h0000, 16'hBEEF, 2'b00, 2'b11, 2'b10, 2'b00, 16'hFF34, 2'b00);
    tbl_a[11] = mk(2'b01, 2'b00, 6'd63, 6'd0,  16'h0000, 16'h0000, 2'b00, 2'b00, 2'b01, 2'b00, 16'hFF34, 2'b00);
    tbl_a[12] = mk(2'b00, 2'b00, 6'd0,  6'd0,  16'h0000, 16'h0000, 2'b00, 2'b00, 2'b00, 2'b01, 16'hBEEF, 2'b00);
    tbl_a[13] = mk(2'b11, 2'b01, 6'd7,  6'd5,  16'h1111, 16'h0000, 2'b11, 2'b00, 2'b10, 2'b00, 16'hBEEF, 2'b00);
    tbl_a[14] = mk(2'b11, 2'b01, 6'd7,  6'd5,  16'h1111, 16'h0000, 2'b11, 2'b00, 2'b01, 2'b10, 16'hA5C3, 2'b00);
    tbl_a[15] = mk(2'b11, 2'b01, 6'd7,  6'd5,  16'h1111, 16'h0000, 2'b11, 2'b00, 2'b10, 2'b00, 16'hA5C3, 2'b00);
    tbl_a[16] = mk(2'b00, 2'b00, 6'd0,  6'd0,  16'h0000, 16'h0000, 2'b00, 2'b00, 2'b00, 2'b10, 16'hA5C3, 2'b00);

    tbl_b[0]  = mk(2'b01, 2'b01, 6'd47, 6'd0,  16'h4747, 16'h0000, 2'b11, 2'b00, 2'b01, 2'b00, 16'h0000, 2'b00);
    tbl_b[1]  = mk(2'b01, 2'b00, 6'd47, 6'd0,  16'h0000, 16'h0000, 2'b00, 2'b00, 2'b01, 2'b00, 16'h0000, 2'b00);
    tbl_b[2]  = mk(2'b10, 2'b10, 6'd0,  6'd50, 16'h0000, 16'h7777, 2'b00, 2'b11, 2'b10, 2'b01, 16'h4747, 2'b00);
    tbl_b[3]  = mk(2'b10, 2'b00, 6'd0,  6'd50, 16'h0000, 16'h0000, 2'b00, 2'b00, 2'b10, 2'b00, 16'h4747, 2'b10);
    tbl_b[4]  = mk(2'b01, 2'b00, 6'd47, 6'd0,  16'h0000, 16'h0000, 2'b00, 2'b00, 2'b01, 2'b10, 16'h0000, 2'b10);
    tbl_b[5]  = mk(2'b00, 2'b00, 6'd0,  6'd0,  16'h0000, 16'h0000, 2'b00, 2'b00, 2'b00, 2'b01, 16'h4747, 2'b00);

    // ---------------------------------------------------------- reset values
    rst_n = 1'b0;
    idle_all();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst rdata",  32'(bus_a.rdata_o),  32'h0);
    check("rst rvalid", 32'(bus_a.rvalid_o), 32'h0);
    check("rst err",    32'(bus_a.err_o),    32'h0);
    check("rst ready idle", 32'(bus_a.ready_o), 32'h0);
    bus_a.valid_i = 2'b10;
    #1 check("rst ready p1 only", 32'(bus_a.ready_o), 32'b10);
    bus_a.valid_i = 2'b11;
    #1 check("rst ready both", 32'(bus_a.ready_o), 32'b01);
    idle_all();
    @(negedge clk);
    rst_n = 1'b1;

    // ------------------------------------------------- directed table, A
    for (int i = 0; i < 17; i++) apply_vec(tbl_a[i], 1'b0, $sformatf("tblA%0d", i));

    // ------------------------------- contention from reset: 0,1,0,1 grants
    reset_pulse();
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1 drive_a(2'b11, 2'b01, 6'd20, 6'd20, 16'(k), 16'h0000, 2'b11, 2'b00);
      @(negedge clk);
      check($sformatf("rr k%0d ready", k), 32'(bus_a.ready_o), (k % 2 == 0) ? 32'b01 : 32'b10);
      check($sformatf("rr k%0d rvalid", k), 32'(bus_a.rvalid_o),
            (k >= 2 && k % 2 == 0) ? 32'b10 : 32'b00);
      if (k >= 2 && k % 2 == 0)
        check($sformatf("rr k%0d rdata", k), 32'(bus_a.rdata_o), 32'(k - 2));
    end

    // ------------------------------------------------ reset mid-operation
    @(posedge clk);
    #1 drive_a(2'b01, 2'b01, 6'd3, 6'd0, 16'h3333, 16'h0000, 2'b11, 2'b00);
    @(posedge clk);
    #1 drive_a(2'b01, 2'b00, 6'd3, 6'd0, 16'h0000, 16'h0000, 2'b00, 2'b00);
    @(posedge clk);
    #1 drive_a(2'b00, 2'b00, 6'd0, 6'd0, 16'h0000, 16'h0000, 2'b00, 2'b00);
    @(negedge clk);
    check("mid pre rvalid", 32'(bus_a.rvalid_o), 32'b01);
    check("mid pre rdata",  32'(bus_a.rdata_o),  32'h3333);
    @(posedge clk);
    #1 drive_a(2'b01, 2'b00, 6'd3, 6'd0, 16'h0000, 16'h0000, 2'b00, 2'b00);
    #2 rst_n = 1'b0;
    #1;
    check("mid rst rvalid", 32'(bus_a.rvalid_o), 32'h0);
    check("mid rst rdata",  32'(bus_a.rdata_o),  32'h0);
    drive_a(2'b01, 2'b01, 6'd3, 6'd0, 16'hDEAD, 16'h0000, 2'b11, 2'b00);
    @(posedge clk);
    #1;
    check("mid edge rvalid", 32'(bus_a.rvalid_o), 32'h0);
    check("mid edge rdata",  32'(bus_a.rdata_o),  32'h0);
    drive_a(2'b11, 2'b00, 6'd3, 6'd3, 16'h0000, 16'h0000, 2'b00, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("mid post ready", 32'(bus_a.ready_o), 32'b01);
    @(posedge clk);
    #1 drive_a(2'b00, 2'b00, 6'd0, 6'd0, 16'h0000, 16'h0000, 2'b00, 2'b00);
    @(negedge clk);
    check("mid post rvalid", 32'(bus_a.rvalid_o), 32'b01);
    check("mid post rdata",  32'(bus_a.rdata_o),  32'h3333);

    // ------------------------------------------- DEPTH=48 table, instance B
    reset_pulse();
    for (int i = 0; i < 6; i++) apply_vec(tbl_b[i], 1'b1, $sformatf("tblB%0d", i));

    // ------------------------------------------- randomized run, instance B
    reset_pulse();
    m_ptr = 0; m_rdata = 16'h0; m_rvalid = 2'b00; m_err = 2'b00;
    s_valid = 2'b01; s_wr = 2'b01;
    s_addr[1] = 6'd0; s_data[1] = 16'h0; s_be[1] = 2'b00;
    for (int a = 0; a < DEPTH_B; a++) begin
      s_addr[0] = 6'(a); s_data[0] = 16'($urandom); s_be[0] = 2'b11;
      rand_cycle(g);
    end
    last_g = 2'b11;
    for (int n = 0; n < 400; n++) begin
      for (int p = 0; p < 2; p++) begin
        if (!s_valid[p] || last_g[p] || $urandom_range(7, 0) == 0) begin
          s_valid[p] = ($urandom_range(3, 0) != 0);
          s_wr[p]    = 1'($urandom);
          s_addr[p]  = 6'($urandom_range(63, 0));
          s_data[p]  = 16'($urandom);
          s_be[p]    = 2'($urandom);
        end
      end
      rand_cycle(g);
      last_g = g;
    end
    s_valid = 2'b00;
    rand_cycle(g);
    rand_cycle(g);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
